// File: rtl/dp_sequencer.sv
// Per-sample datapath sequencer: main sample read, each enabled effect stage with a
// start/done handshake and timeout, ready flag, then SPI handoff. All outputs registered.
module dp_sequencer #(
    parameter int unsigned N_FX       = 2,
    parameter int unsigned FX_TIMEOUT = 255,
    parameter int unsigned IDXW       = (N_FX > 1) ? $clog2(N_FX) : 1,
    parameter int unsigned TW         = $clog2(FX_TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N_FX-1:0] fx_en,
    input  logic            main_done,
    input  logic [N_FX-1:0] fx_done,
    input  logic            spi_busy,
    output logic            main_read,
    output logic [N_FX-1:0] fx_start,
    output logic [IDXW-1:0] fx_idx,
    output logic            ready,
    output logic            spi_start,
    output logic            busy,
    output logic            overrun,
    output logic [7:0]      overrun_cnt,
    output logic [N_FX-1:0] timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StReadMain,
        StWaitMain,
        StFxIssue,
        StFxWait,
        StReady,
        StSpiStart,
        StSpiWait
    } state_t;

    state_t          state;
    logic [N_FX-1:0] en_q;
    logic [TW-1:0]   tmo_cnt;
    logic [TW-1:0]   tmo_nxt;
    logic            spi_first;

    logic [IDXW-1:0] first_idx;
    logic            first_vld;
    logic [IDXW-1:0] next_idx;
    logic            next_vld;
    logic            stage_done;
    logic            stage_abandon;

    // Scanning downwards leaves the lowest qualifying index in place.
    always_comb begin
        first_idx = '0;
        first_vld = 1'b0;
        next_idx  = '0;
        next_vld  = 1'b0;
        for (int i = int'(N_FX) - 1; i >= 0; i--) begin
            if (en_q[i]) begin
                first_idx = IDXW'(i);
                first_vld = 1'b1;
            end
            if (en_q[i] && (i > int'(fx_idx))) begin
                next_idx = IDXW'(i);
                next_vld = 1'b1;
            end
        end
    end

    assign tmo_nxt       = tmo_cnt + TW'(1);
    assign stage_done    = fx_done[fx_idx];
    assign stage_abandon = (tmo_nxt == TW'(FX_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            en_q        <= '0;
            tmo_cnt     <= '0;
            spi_first   <= 1'b0;
            main_read   <= 1'b0;
            fx_start    <= '0;
            fx_idx      <= '0;
            ready       <= 1'b0;
            spi_start   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            timeout_err <= '0;
        end else begin
            main_read <= 1'b0;
            fx_start  <= '0;
            ready     <= 1'b0;
            spi_start <= 1'b0;
            overrun   <= 1'b0;

            // A tick that lands while a sequence is in flight is dropped, only counted.
            if (start && (state != StIdle)) begin
                overrun <= 1'b1;
                if (overrun_cnt != 8'hff) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StReadMain;
                        en_q      <= fx_en;
                        main_read <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StReadMain: state <= StWaitMain;
                StWaitMain: begin
                    if (main_done) begin
                        if (first_vld) begin
                            fx_idx   <= first_idx;
                            fx_start <= N_FX'(1) << first_idx;
                            state    <= StFxIssue;
                        end else begin
                            ready <= 1'b1;
                            state <= StReady;
                        end
                    end
                end
                StFxIssue: begin
                    tmo_cnt <= '0;
                    state   <= StFxWait;
                end
                StFxWait: begin
                    if (stage_done || stage_abandon) begin
                        // A done arriving on the last allowed cycle still wins.
                        if (!stage_done) begin
                            timeout_err[fx_idx] <= 1'b1;
                        end
                        if (next_vld) begin
                            fx_idx   <= next_idx;
                            fx_start <= N_FX'(1) << next_idx;
                            state    <= StFxIssue;
                        end else begin
                            ready <= 1'b1;
                            state <= StReady;
                        end
                    end else begin
                        tmo_cnt <= tmo_nxt;
                    end
                end
                StReady: begin
                    spi_start <= 1'b1;
                    state     <= StSpiStart;
                end
                StSpiStart: begin
                    spi_first <= 1'b1;
                    state     <= StSpiWait;
                end
                StSpiWait: begin
                    // First cycle ignores spi_busy: the slave may raise it a cycle late.
                    if (spi_first) begin
                        spi_first <= 1'b0;
                    end else if (!spi_busy) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Randomised bench for dp_sequencer: a per-sequence timeline model predicts every output
// slot from the chosen main/stage/SPI delays, and each slot is compared against the DUT.
module tb_dp_sequencer;

    localparam int unsigned NFX = 2;
    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] fx_en;
    logic       main_done;
    logic [1:0] fx_done;
    logic       spi_busy;
    logic       main_read;
    logic [1:0] fx_start;
    logic [0:0] fx_idx;
    logic       ready;
    logic       spi_start;
    logic       busy;
    logic       overrun;
    logic [7:0] overrun_cnt;
    logic [1:0] timeout_err;

    dp_sequencer #(
        .N_FX       (NFX),
        .FX_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .fx_en       (fx_en),
        .main_done   (main_done),
        .fx_done     (fx_done),
        .spi_busy    (spi_busy),
        .main_read   (main_read),
        .fx_start    (fx_start),
        .fx_idx      (fx_idx),
        .ready       (ready),
        .spi_start   (spi_start),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_cnt    = 0;
    logic [1:0] m_terr   = '0;
    int         m_idx    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input bit mr, input logic [1:0] fs, input int idx, input bit rd,
                             input bit ss, input bit bz, input bit ov);
        check("main_read", 32'(main_read), 32'(mr));
        check("fx_start", 32'(fx_start), 32'(fs));
        check("fx_idx", 32'(fx_idx), 32'(idx));
        check("ready", 32'(ready), 32'(rd));
        check("spi_start", 32'(spi_start), 32'(ss));
        check("busy", 32'(busy), 32'(bz));
        check("overrun", 32'(overrun), 32'(ov));
        check("overrun_cnt", 32'(overrun_cnt), 32'(m_cnt));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic apply_reset();
        start     = 1'b0;
        main_done = 1'b0;
        fx_done   = '0;
        spi_busy  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        m_cnt  = 0;
        m_terr = '0;
        m_idx  = 0;
        check_all(0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all(0, 2'b00, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            start     = 1'b0;
            main_done = 1'b0;
            fx_en     = 2'($urandom);
            fx_done   = 2'($urandom);
            spi_busy  = 1'($urandom);
            @(posedge clk);
            #1;
            check_all(0, 2'b00, m_idx, 0, 0, 0, 0);
        end
    endtask

    // Slot k = outputs just after the k-th edge, start being sampled at edge 0.
    // md: edge offset of main_done after edge 1; d*: wait cycles until that stage's done
    // (beyond TMO means never); h: SPI busy cycles from the SPI_START edge on.
    // mode bits: 0 random overruns, 1 start held mid-sequence, 2 start on exit edge,
    // 3 starts at edges 2/4/6. abort_k >= 0 asserts reset before that edge.
    task automatic run_seq(input logic [1:0] en, input int md, input int d0, input int d1,
                           input int h, input int mode, input int abort_k);
        int         d[2];
        int         iss[2];
        int         endk[2];
        bit         tmo_hit[2];
        int         s, r, x, own, eff;
        logic [1:0] fs_exp;
        bit         st;
        d[0] = d0;
        d[1] = d1;
        s = 1 + md;
        for (int i = 0; i < 2; i++) begin
            iss[i] = -1;
            endk[i] = -1;
            tmo_hit[i] = 1'b0;
            if (en[i]) begin
                eff = (d[i] > int'(TMO)) ? int'(TMO) : d[i];
                tmo_hit[i] = d[i] > int'(TMO);
                iss[i] = s;
                endk[i] = s + 1 + eff;
                s = endk[i];
            end
        end
        r = s;
        x = (h >= 2) ? r + 2 + h : r + 4;
        for (int k = 0; k <= x; k++) begin
            if (k == abort_k) begin
                apply_reset();
                return;
            end
            st = (k == 0);
            if (k >= 1 && k < x) begin
                if (mode[0] && $urandom_range(0, 3) == 0) st = 1'b1;
                if (mode[1]) st = 1'b1;
                if (mode[3] && (k == 2 || k == 4 || k == 6)) st = 1'b1;
            end
            if (k == x && mode[2]) st = 1'b1;
            start     = st;
            fx_en     = (k == 0) ? en : 2'($urandom);
            main_done = (k == 1 + md);
            own = -1;
            for (int i = 0; i < 2; i++) begin
                if (en[i] && k > iss[i] && k <= endk[i]) own = i;
            end
            fx_done = 2'($urandom);
            if (own >= 0) fx_done[own] = (k == iss[own] + 1 + d[own]) && !tmo_hit[own];
            spi_busy = (k < r + 2) ? 1'($urandom) : (k <= r + 1 + h);
            @(posedge clk);
            #1;
            if (st && k >= 1) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            fs_exp = '0;
            for (int i = 0; i < 2; i++) begin
                if (k == iss[i]) begin
                    fs_exp[i] = 1'b1;
                    m_idx = i;
                end
                if (tmo_hit[i] && k == endk[i]) m_terr[i] = 1'b1;
            end
            check_all(k == 0, fs_exp, m_idx, k == r, k == r + 1, k < x, st && k >= 1);
        end
        start     = 1'b0;
        main_done = 1'b0;
        fx_done   = '0;
        spi_busy  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        fx_en     = '0;
        main_done = 1'b0;
        fx_done   = '0;
        spi_busy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, 2'b00, 0, 0, 0, 0, 0);
        reset = 1'b0;
        idle_cycles(2);

        run_seq(2'b11, 2, 3, 3, 4, 0, -1);
        idle_cycles(1);
        run_seq(2'b11, 1, 1, 1, 0, 12, -1);
        run_seq(2'b00, 2, 1, 1, 2, 0, -1);
        run_seq(2'b10, 1, 3, 3, 1, 0, -1);
        run_seq(2'b11, 1, int'(TMO), 2, 0, 0, -1);
        run_seq(2'b11, 1, 100, 2, 3, 0, -1);
        idle_cycles(1);

        for (int n = 0; n < 30; n++) begin
            run_seq(2'($urandom), $urandom_range(1, 5), $urandom_range(1, TMO + 3),
                    $urandom_range(1, TMO + 3), $urandom_range(0, 6),
                    $urandom_range(0, 1) | ($urandom_range(0, 1) << 2), -1);
            idle_cycles($urandom_range(0, 2));
        end

        run_seq(2'b11, 1, 1, 1, 300, 2, -1);
        idle_cycles(1);

        run_seq(2'b11, 1, 5, 2, 0, 0, 5);
        idle_cycles(1);
        run_seq(2'b11, 1, 2, 2, 1, 0, -1);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Per-sample datapath sequencer for the audio effects pipeline. It generalises the fixed pause/read/ready/SPI controller to N_FX effect stages, each with a runtime enable mask.
- On each sample tick it does four things in order: reads the main sample, runs each enabled effect stage with a start/done handshake and a timeout, flags the result ready, then hands off to the MCU SPI transmitter.
- Sits between the sample-rate tick generator and the effect units / SPI slave.

Parameters:
- N_FX, 2, number of effect stages (index 0 = first in chain, e.g. chorus; 1 = reverb); range 1..8.
- FX_TIMEOUT, 255, max cycles to wait for fx_done before abandoning a stage; ≥1.
- IDXW, $clog2(N_FX) (min 1), width of fx_idx.
- TW, $clog2(FX_TIMEOUT+1), width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- start  in  1  sample tick; accepted only in IDLE
- fx_en  in  N_FX  stage enable mask; sampled into en_q on the cycle start is accepted
- main_done  in  1  main-sample read complete
- fx_done  in  N_FX  per-stage done; only the active stage's bit is observed
- spi_busy  in  1  SPI transmitter busy
- main_read  out  1  one-cycle pulse, begin main sample read
- fx_start  out  N_FX  one-hot one-cycle pulse to the active stage
- fx_idx  out  IDXW  index of the active/last-issued stage
- ready  out  1  one-cycle pulse, processed sample valid
- spi_start  out  1  one-cycle pulse, begin SPI transfer
- busy  out  1  high in every state except IDLE
- overrun  out  1  one-cycle pulse when start arrives while not IDLE
- overrun_cnt  out  8  saturating count of overruns
- timeout_err  out  N_FX  sticky per-stage timeout flags

Behaviour:
- Reset: state=IDLE. All outputs 0: main_read, fx_start, fx_idx, ready, spi_start, busy, overrun, overrun_cnt, timeout_err. en_q and the timeout counter also clear. Reset asserted mid-sequence aborts immediately; no further pulses.
- All outputs are registered/Moore. Pulses last exactly one cycle.
- States: IDLE, READ_MAIN, WAIT_MAIN, FX_ISSUE, FX_WAIT, READY, SPI_START, SPI_WAIT.
- IDLE: start=1 → READ_MAIN and en_q<=fx_en. main_read is high the cycle after start is sampled (latency 1).
- READ_MAIN (1 cycle) → WAIT_MAIN.
- WAIT_MAIN: wait for main_done=1, with no timeout. Then:
  - if en_q≠0: fx_idx <= lowest set bit of en_q, → FX_ISSUE;
  - else → READY.
- FX_ISSUE (1 cycle): fx_start[fx_idx]=1, timeout counter cleared → FX_WAIT.
- FX_WAIT: each cycle, if fx_done[fx_idx]=1 the stage completes. Otherwise the counter increments; on reaching FX_TIMEOUT, timeout_err[fx_idx]<=1 and the stage is abandoned.
  - On complete or abandon: next = lowest set bit of en_q strictly above fx_idx. If one exists → FX_ISSUE with that index, else → READY.
  - fx_done bits for other indices are ignored.
  - fx_done in the same cycle the counter reaches FX_TIMEOUT counts as done; no error is flagged.
- READY (1 cycle, ready=1) → SPI_START.
- SPI_START (1 cycle, spi_start=1) → SPI_WAIT.
- SPI_WAIT: stays at least 1 cycle. Leaves to IDLE on the first cycle with spi_busy=0, counting from the second SPI_WAIT cycle. This tolerates a slave that raises busy one cycle late.
- Overrun: start=1 in any non-IDLE state:
  - overrun pulses next cycle; overrun_cnt increments, saturating at 255;
  - the start is dropped, and sequencing continues unaffected.
- start in the same cycle the FSM returns SPI_WAIT→IDLE: FSM is not yet in IDLE, so this counts as overrun.
- fx_en changes mid-sequence have no effect (en_q is frozen).
- timeout_err and overrun_cnt clear only on reset.
- Minimum sequence length with all done signals immediate:
  - 2 + 2·(enabled stages) + 1 + 1 + 2 cycles, IDLE to IDLE;
  - with N_FX=2, both enabled: 10 cycles.

Test Plan:
- Reset, N_FX=2, fx_en=2'b11, start pulse; main_done 2 cycles after main_read; each fx_done 3 cycles after its fx_start; spi_busy high 4 cycles → exactly one main_read, fx_start=01 then 10, one ready, one spi_start; busy low after spi_busy falls; timeout_err=0.
- fx_en=2'b00, start → main_read, then ready directly; no fx_start pulses.
- fx_en=2'b10 → single fx_start=2'b10 with fx_idx=1; fx_done[0] pulsed during FX_WAIT is ignored.
- FX_TIMEOUT=8, fx_en=2'b11, stage 0 never done → after 8 FX_WAIT cycles timeout_err=2'b01, stage 1 issued, ready still produced.
- start pulsed 3 times during one sequence, and once in the SPI_WAIT exit cycle → 4 overrun pulses, overrun_cnt=4, single ready. Apply 300 overruns → overrun_cnt=255.
- Reset asserted during FX_WAIT → next cycle all outputs 0 and state IDLE; a subsequent start runs a clean full sequence.
